unidade_controle: RTL

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

---
 rtl/unidade_controle.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB for a small RISC-V subset.
// Optional CONTROLE_PERF_EN adds a cycle_count port counting active (non-IDLE, non-HALT) cycles.
module unidade_controle #(
    parameter int unsigned MEM_TIMEOUT = 15   // must be >= 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] instru,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        pc_en,
    output logic        load_en,
    output logic        store_en,
    output logic [1:0]  op_ula,
    output logic [1:0]  operation_type,
    output logic        ula_entry,
    output logic        branch,
    output logic        auipc,
    output logic        jal,
    output logic        jalr,
    output logic        sign,
    output logic [2:0]  estado,
    output logic        halted,
    output logic        error,
`ifdef CONTROLE_PERF_EN
    output logic [31:0] cycle_count,
`endif
    output logic [31:0] instr_count
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       is_mem;
        logic       is_store;
        logic       wr_reg;
        logic [1:0] op_ula;
        logic [1:0] op_type;
        logic       ula_entry;
        logic       branch;
        logic       auipc;
        logic       jal;
        logic       jalr;
        logic       sign;
    } dec_t;

    // Instruction decode from opcode, funct3 and funct7[5].
    function automatic dec_t decode(input logic [6:0] opc, input logic [2:0] f3, input logic f7b5);
        dec_t d;
        d = '0;
        case (opc)
            OPC_R: begin
                d.ula_entry = 1'b1;
                d.wr_reg    = 1'b1;
                case (f3)
                    3'b000: begin d.legal = 1'b1; d.op_ula = f7b5 ? 2'b01 : 2'b00; end
                    3'b010: begin d.legal = 1'b1; d.op_ula = 2'b10; d.sign = 1'b1; end
                    3'b011: begin d.legal = 1'b1; d.op_ula = 2'b10; end
                    default: ;
                endcase
            end
            OPC_I: begin
                d.wr_reg = 1'b1;
                case (f3)
                    3'b000: d.legal = 1'b1;
                    3'b010: begin d.legal = 1'b1; d.op_ula = 2'b10; d.sign = 1'b1; end
                    3'b011: begin d.legal = 1'b1; d.op_ula = 2'b10; end
                    default: ;
                endcase
            end
            OPC_LOAD: begin
                d.legal   = (f3 == 3'b011);
                d.is_mem  = 1'b1;
                d.wr_reg  = 1'b1;
                d.op_type = 2'b01;
            end
            OPC_STORE: begin
                d.legal    = (f3 == 3'b011);
                d.is_mem   = 1'b1;
                d.is_store = 1'b1;
            end
            OPC_BRANCH: begin
                d.branch    = 1'b1;
                d.ula_entry = 1'b1;
                case (f3)
                    3'b000, 3'b001: begin d.legal = 1'b1; d.op_ula = 2'b11; d.sign = 1'b1; end
                    3'b100, 3'b101: begin d.legal = 1'b1; d.op_ula = 2'b10; d.sign = 1'b1; end
                    3'b110, 3'b111: begin d.legal = 1'b1; d.op_ula = 2'b10; end
                    default: ;
                endcase
            end
            OPC_JAL:   begin d.legal = 1'b1; d.jal   = 1'b1; d.wr_reg = 1'b1; d.op_type = 2'b10; end
            OPC_JALR:  begin d.legal = 1'b1; d.jalr  = 1'b1; d.wr_reg = 1'b1; d.op_type = 2'b10; end
            OPC_AUIPC: begin d.legal = 1'b1; d.auipc = 1'b1; d.wr_reg = 1'b1; d.op_type = 2'b10; end
            default: ;
        endcase
        return d;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_instr;
    logic [WAIT_W-1:0] r_wait;
    logic              w_err_set;
    logic              w_in_decode;
    logic [6:0]        w_opc;
    logic [2:0]        w_f3;
    logic              w_f7b5;
    dec_t              w_dec;
    logic              w_sel_valid;
    logic              w_unused_instr;

    // DECODE judges the live instruction; outputs for EXEC onward come from the latched copy.
    assign w_in_decode    = (r_state == S_DECODE);
    assign w_opc          = w_in_decode ? instru[6:0]   : r_instr[6:0];
    assign w_f3           = w_in_decode ? instru[14:12] : r_instr[14:12];
    assign w_f7b5         = w_in_decode ? instru[30]    : r_instr[30];
    assign w_dec          = decode(w_opc, w_f3, w_f7b5);
    assign w_unused_instr = ^{r_instr[31], r_instr[29:15], r_instr[11:7]};

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_FETCH;
            S_FETCH:  w_state_nxt = S_DECODE;
            S_DECODE: begin
                if (instru == EBREAK) begin
                    w_state_nxt = S_HALT;
                end else if (!w_dec.legal) begin
                    w_state_nxt = S_HALT;
                    w_err_set   = 1'b1;
                end else begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC:   w_state_nxt = w_dec.is_mem ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ready) begin
                    w_state_nxt = S_WB;
                end else if (r_wait == WAIT_LAST) begin
                    w_state_nxt = S_HALT;
                    w_err_set   = 1'b1;
                end
            end
            S_WB:     w_state_nxt = S_FETCH;
            S_HALT:   if (start) w_state_nxt = S_FETCH;
            default: begin
                w_state_nxt = S_HALT;
                w_err_set   = 1'b1;
            end
        endcase
    end

    assign w_sel_valid = (w_state_nxt == S_EXEC) || (w_state_nxt == S_MEM) || (w_state_nxt == S_WB);
    assign estado      = r_state;

    // Registered outputs are computed from the next state so they line up with estado.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr        <= '0;
            r_wait         <= '0;
            mem_req        <= 1'b0;
            store_en       <= 1'b0;
            pc_en          <= 1'b0;
            load_en        <= 1'b0;
            op_ula         <= 2'b00;
            operation_type <= 2'b00;
            ula_entry      <= 1'b0;
            branch         <= 1'b0;
            auipc          <= 1'b0;
            jal            <= 1'b0;
            jalr           <= 1'b0;
            sign           <= 1'b0;
            halted         <= 1'b0;
            error          <= 1'b0;
            instr_count    <= '0;
        end else begin
            if (w_in_decode) r_instr <= instru;
            r_wait         <= (r_state == S_MEM) ? r_wait + WAIT_W'(1) : '0;
            mem_req        <= (w_state_nxt == S_MEM);
            store_en       <= (w_state_nxt == S_MEM) && w_dec.is_store;
            pc_en          <= (w_state_nxt == S_WB);
            load_en        <= (w_state_nxt == S_WB) && w_dec.wr_reg;
            op_ula         <= w_sel_valid ? w_dec.op_ula  : 2'b00;
            operation_type <= w_sel_valid ? w_dec.op_type : 2'b00;
            ula_entry      <= w_sel_valid && w_dec.ula_entry;
            branch         <= w_sel_valid && w_dec.branch;
            auipc          <= w_sel_valid && w_dec.auipc;
            jal            <= w_sel_valid && w_dec.jal;
            jalr           <= w_sel_valid && w_dec.jalr;
            sign           <= w_sel_valid && w_dec.sign;
            halted         <= (w_state_nxt == S_HALT);
            if (r_state == S_HALT && start) begin
                error <= 1'b0;
            end else if (w_err_set) begin
                error <= 1'b1;
            end
            if (w_state_nxt == S_WB) instr_count <= instr_count + 32'd1;
        end
    end

`ifdef CONTROLE_PERF_EN
    // Active-cycle counter, frozen in IDLE and HALT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
        end else if (r_state != S_IDLE && r_state != S_HALT) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

endmodule
